// File: rtl/rf_write_arbiter_if.sv
// Bundles the requester, register-file-port, hazard-check and counter signals of rf_write_arbiter.
// The arbiter connects through the slave modport; the requesters/environment use the master modport.
interface rf_write_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned CNT_W  = 16
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_rd;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_rd;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              rf_write;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_wdata;
  logic [ADDR_W-1:0] chk_rs;
  logic [ADDR_W-1:0] chk_rt;
  logic              hazard;
  logic [CNT_W-1:0]  conflict_cnt;

  modport slave (
    input  req0_valid, req0_rd, req0_data,
    output req0_ready,
    input  req1_valid, req1_rd, req1_data,
    output req1_ready,
    output rf_write, rf_rd, rf_wdata,
    input  chk_rs, chk_rt,
    output hazard, conflict_cnt
  );

  modport master (
    output req0_valid, req0_rd, req0_data,
    input  req0_ready,
    output req1_valid, req1_rd, req1_data,
    input  req1_ready,
    input  rf_write, rf_rd, rf_wdata,
    output chk_rs, chk_rt,
    input  hazard, conflict_cnt
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU (0) and load (1) writeback.
// Define R0_PROTECT_EN to silently drop writes to register 0 and exclude it from hazard detection.
module rf_write_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned CNT_W  = 16
) (
  input logic clock,
  input logic reset,
  rf_write_arbiter_if.slave bus
);

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic {PREF0 = 1'b0, PREF1 = 1'b1} state_e;

  state_e            state_q, state_d;
  logic              s0_full_q, s0_full_d;
  logic              s1_full_q, s1_full_d;
  wb_entry_t         s0_q, s0_d;
  wb_entry_t         s1_q, s1_d;
  logic              rf_write_q, rf_write_d;
  logic [ADDR_W-1:0] rf_rd_q, rf_rd_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic grant0, grant1;
  logic ready0, ready1;
  logic load0, load1;

  // Whether a destination register is a real write target (slot load and hazard eligibility).
  function automatic logic is_target(input logic [ADDR_W-1:0] rd);
`ifdef R0_PROTECT_EN
    return rd != '0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic rd_hit(input logic [ADDR_W-1:0] rd,
                                  input logic [ADDR_W-1:0] rs,
                                  input logic [ADDR_W-1:0] rt);
    return is_target(rd) && ((rd == rs) || (rd == rt));
  endfunction

  // Grants depend only on registered state, so ready never depends on valid.
  always_comb begin
    grant0 = s0_full_q & (~s1_full_q | (state_q == PREF0));
    grant1 = s1_full_q & ~grant0;
    ready0 = ~s0_full_q | grant0;
    ready1 = ~s1_full_q | grant1;
    load0  = bus.req0_valid & ready0 & is_target(bus.req0_rd);
    load1  = bus.req1_valid & ready1 & is_target(bus.req1_rd);
  end

  always_comb begin
    state_d    = state_q;
    s0_full_d  = s0_full_q & ~grant0;
    s1_full_d  = s1_full_q & ~grant1;
    s0_d       = s0_q;
    s1_d       = s1_q;
    rf_write_d = grant0 | grant1;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    cnt_d      = cnt_q;

    if (grant0) begin
      state_d    = PREF1;
      rf_rd_d    = s0_q.rd;
      rf_wdata_d = s0_q.data;
    end else if (grant1) begin
      state_d    = PREF0;
      rf_rd_d    = s1_q.rd;
      rf_wdata_d = s1_q.data;
    end

    // A slot being drained this cycle may reload in the same edge.
    if (load0) begin
      s0_full_d = 1'b1;
      s0_d      = '{rd: bus.req0_rd, data: bus.req0_data};
    end
    if (load1) begin
      s1_full_d = 1'b1;
      s1_d      = '{rd: bus.req1_rd, data: bus.req1_data};
    end

    if (s0_full_q && s1_full_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= PREF0;
      s0_full_q  <= 1'b0;
      s1_full_q  <= 1'b0;
      s0_q       <= '0;
      s1_q       <= '0;
      rf_write_q <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      s0_full_q  <= s0_full_d;
      s1_full_q  <= s1_full_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      rf_write_q <= rf_write_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.req0_ready   = ready0;
  assign bus.req1_ready   = ready1;
  assign bus.rf_write     = rf_write_q;
  assign bus.rf_rd        = rf_rd_q;
  assign bus.rf_wdata     = rf_wdata_q;
  assign bus.conflict_cnt = cnt_q;

  // Any queued or in-flight write whose destination is read by the decode stage.
  assign bus.hazard = (s0_full_q  && rd_hit(s0_q.rd,  bus.chk_rs, bus.chk_rt))
                    | (s1_full_q  && rd_hit(s1_q.rd,  bus.chk_rs, bus.chk_rt))
                    | (rf_write_q && rd_hit(rf_rd_q,  bus.chk_rs, bus.chk_rt));

endmodule
